// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer code conversions and default depth.
// Used by both the read-side and write-side pointer handlers.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_SIZE = 4;
    localparam int unsigned DEPTH          = 2 ** FIFO_ADDR_SIZE;

    // Callers zero-extend narrower pointers; the conversions are width-agnostic.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter for a synchronised pointer.
module gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin_c
);

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        bin_c = '0;
        for (int i = 0; i < W; i++) begin
            bin_c[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Async FIFO read-side pointer/empty logic with a first-word-fall-through
// output register, valid/ready handshake, fill level and almost-empty flag.
module rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = $clog2(DEPTH),
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    input  logic [DATA_SIZE-1:0] rdata_mem,
    input  logic                 rready,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 rvalid,
    output logic [DATA_SIZE-1:0] rdata,
    output logic [ADDR_SIZE+1:0] rlevel,
    output logic                 ralmost_empty
);

    localparam int unsigned PTR_W = ADDR_SIZE + 1;
    localparam int unsigned LVL_W = ADDR_SIZE + 2;

    logic [PTR_W-1:0]     rbin;
    logic [PTR_W-1:0]     rbin_next_c;
    logic [PTR_W-1:0]     rgray_next_c;
    logic [PTR_W-1:0]     wbin_c;
    logic [PTR_W-1:0]     diff_c;
    logic                 fetch_c;
    logic                 rempty_next_c;
    logic                 rvalid_next_c;
    logic [DATA_SIZE-1:0] rdata_next_c;
    logic [LVL_W-1:0]     rlevel_next_c;
    logic                 ralmost_empty_next_c;

    gray2bin #(
        .W(PTR_W)
    ) u_wptr_g2b (
        .gray  (rq2_wptr),
        .bin_c (wbin_c)
    );

    // Fetch pulls the next memory word whenever the output slot is free or
    // being drained; empty is the registered flag so a fresh write waits a cycle.
    always_comb begin
        rvalid_next_c        = rvalid;
        rdata_next_c         = rdata;
        fetch_c              = ~rempty & (~rvalid | rready);
        rbin_next_c          = rbin + PTR_W'(fetch_c);
        rgray_next_c         = PTR_W'(bin2gray(32'(rbin_next_c)));
        rempty_next_c        = (rgray_next_c == rq2_wptr);

        if (fetch_c) begin
            rvalid_next_c = 1'b1;
            rdata_next_c  = rdata_mem;
        end else if (rvalid & rready) begin
            rvalid_next_c = 1'b0;
        end

        // Difference taken at pointer width so it wraps correctly before widening.
        diff_c               = wbin_c - rbin_next_c;
        rlevel_next_c        = LVL_W'(diff_c) + LVL_W'(rvalid_next_c);
        ralmost_empty_next_c = (rlevel_next_c <= LVL_W'(AE_THRESH));
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            rvalid        <= 1'b0;
            rdata         <= '0;
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rbin          <= rbin_next_c;
            rptr          <= rgray_next_c;
            rempty        <= rempty_next_c;
            rvalid        <= rvalid_next_c;
            rdata         <= rdata_next_c;
            rlevel        <= rlevel_next_c;
            ralmost_empty <= ralmost_empty_next_c;
        end
    end

    assign raddr = rbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: directed scenarios plus randomized traffic,
// checked against a word-count/queue model of the FIFO read side.
module tb_rptr_empty_fwft;

    logic       rclk;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata_mem;
    logic       rready;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       rvalid;
    logic [7:0] rdata;
    logic [5:0] rlevel;
    logic       ralmost_empty;

    logic [7:0] mem [16];

    int tests;
    int failed;

    int         m_written;
    int         m_fetched;
    int         m_delivered;
    int         m_w_seen;
    bit         m_valid;
    logic [7:0] m_word;
    logic [7:0] wq[$];
    logic [7:0] obs_data;

    rptr_empty_fwft #(
        .ADDR_SIZE(4),
        .DATA_SIZE(8),
        .AE_THRESH(2)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rq2_wptr      (rq2_wptr),
        .rdata_mem     (rdata_mem),
        .rready        (rready),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty)
    );

    assign rdata_mem = mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] g5(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_written   = 0;
        m_fetched   = 0;
        m_delivered = 0;
        m_w_seen    = 0;
        m_valid     = 1'b0;
        m_word      = 8'h00;
        obs_data    = 8'h00;
        wq.delete();
    endtask

    // Writer side: store the word, publish the new gray write count.
    task automatic wr(input logic [7:0] d);
        if (m_written - m_fetched < 16) begin
            mem[m_written % 16] = d;
            wq.push_back(d);
            m_written++;
            rq2_wptr = g5(m_written);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_rvalid"}, 32'(rvalid), 32'd0);
        check({pfx, "_rempty"}, 32'(rempty), 32'd1);
        check({pfx, "_rptr"}, 32'(rptr), 32'd0);
        check({pfx, "_raddr"}, 32'(raddr), 32'd0);
        check({pfx, "_rdata"}, 32'(rdata), 32'd0);
        check({pfx, "_rlevel"}, 32'(rlevel), 32'd0);
        check({pfx, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
    endtask

    // One rclk edge: advance the model, then compare every output.
    task automatic step();
        bit fetch;
        bit xfer;
        int lvl;
        @(posedge rclk);
        xfer  = m_valid && rready;
        fetch = (m_fetched != m_w_seen) && (!m_valid || rready);
        if (xfer) begin
            check("xfer_data", 32'(obs_data), 32'(wq[m_delivered]));
            m_delivered++;
        end
        if (fetch) begin
            m_word  = wq[m_fetched];
            m_fetched++;
            m_valid = 1'b1;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        m_w_seen = m_written;
        #1;
        lvl = m_w_seen - m_delivered;
        check("rvalid", 32'(rvalid), 32'(m_valid));
        check("rdata", 32'(rdata), 32'(m_word));
        check("rptr", 32'(rptr), 32'(g5(m_fetched)));
        check("raddr", 32'(raddr), 32'(m_fetched % 16));
        check("rempty", 32'(rempty), 32'(m_fetched == m_w_seen));
        check("rlevel", 32'(rlevel), 32'(lvl));
        check("ralmost_empty", 32'(ralmost_empty), 32'(lvl <= 2));
        obs_data = rdata;
    endtask

    task automatic do_reset();
        rrst     = 1'b1;
        rready   = 1'b0;
        rq2_wptr = 5'b00000;
        #1;
        model_clear();
        check_reset("rst_async");
        @(posedge rclk);
        #1;
        check_reset("rst_held");
        rrst = 1'b0;
        step();
        step();
    endtask

    initial begin
        int p;
        int n;
        tests  = 0;
        failed = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        model_clear();
        rready   = 1'b0;
        rq2_wptr = 5'b00000;
        rrst     = 1'b0;
        #1;
        rrst = 1'b1;

        // Reset state and idle after release
        do_reset();
        check_reset("rst_idle");

        // Single word with fall-through
        wr(8'hA5);
        step();
        check("t2_rempty", 32'(rempty), 32'd0);
        check("t2_rvalid_early", 32'(rvalid), 32'd0);
        step();
        check("t2_rvalid", 32'(rvalid), 32'd1);
        check("t2_rdata", 32'(rdata), 32'hA5);
        check("t2_rptr", 32'(rptr), 32'b00001);
        check("t2_rlevel", 32'(rlevel), 32'd1);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("t2_rvalid_done", 32'(rvalid), 32'd0);
        check("t2_rlevel_done", 32'(rlevel), 32'd0);

        // Backpressure with three words available
        do_reset();
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        step();
        step();
        check("t3_raddr", 32'(raddr), 32'd1);
        check("t3_rlevel", 32'(rlevel), 32'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold", 32'(rdata), 32'h11);
            check("t3_raddr_hold", 32'(raddr), 32'd1);
        end
        rready = 1'b1;
        step();
        check("t3_second", 32'(rdata), 32'h22);
        step();
        check("t3_third", 32'(rdata), 32'h33);
        step();
        check("t3_drained", 32'(rvalid), 32'd0);
        rready = 1'b0;
        step();

        // Full drain of 16 words
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'(i * 9 + 1));
        check("t4_wptr", 32'(rq2_wptr), 32'b11000);
        rready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t4_rptr", 32'(rptr), 32'b11000);
        check("t4_rempty", 32'(rempty), 32'd1);
        check("t4_rvalid", 32'(rvalid), 32'd0);

        // Pointer wrap across 32 reads
        for (int i = 0; i < 14; i++) wr(8'(8'h40 + i));
        for (int i = 0; i < 20; i++) step();
        check("t5_rptr30", 32'(rptr), 32'b10001);
        for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
        for (int i = 0; i < 8; i++) step();
        check("t5_rptr", 32'(rptr), 32'b00011);
        check("t5_raddr", 32'(raddr), 32'd2);
        check("t5_rempty", 32'(rempty), 32'd1);

        // Async reset while holding a word with level 5
        rready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'(8'h70 + i));
        for (int i = 0; i < 4; i++) step();
        check("t6_rvalid", 32'(rvalid), 32'd1);
        check("t6_rlevel", 32'(rlevel), 32'd5);
        #2;
        do_reset();

        // Randomized traffic with varying consumer duty cycle
        for (int blk = 0; blk < 8; blk++) begin
            p = int'($urandom_range(5, 95));
            for (int c = 0; c < 100; c++) begin
                rready = ($urandom_range(0, 99) < p);
                n = int'($urandom_range(0, 2));
                for (int k = 0; k < n; k++) wr(8'($urandom));
                step();
            end
        end
        rready = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("rand_empty", 32'(rempty), 32'd1);
        check("rand_count", 32'(m_delivered), 32'(m_written));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
